vga_timing_gen: RTL and testbench

- Parametrised raster timing generator; successor to the fixed 640x480 VGA controller.
- Generates a pixel clock-enable from the system clock, not a derived clock, so downstream logic stays on one clock domain.
- Produces sync, blank, pixel coordinates, a programmable playfield window flag and frame/line event pulses for game logic.
- Sits between the board clock and the colour mapper / VGA DAC.

---
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised raster timing generator. A prescaler produces a pixel
// clock-enable from the system clock, so all downstream logic stays on Clk.
// Coordinates advance on each pixel_ce. Sync, blank and window flags are
// registered from the *next* coordinates, so they always describe the pixel
// currently held in (DrawX, DrawY), with no skew between them.
//
// Ports:
//   Clk          system clock
//   Reset_n      synchronous active-low reset (has priority over Enable)
//   Enable       1 = run, 0 = freeze all timing state
//   pixel_ce     one-Clk pulse per pixel
//   hs, vs       horizontal / vertical sync, asserted at HS_POL / VS_POL
//   blank        1 = visible pixel
//   sync         composite sync, tied 0
//   in_window    current pixel lies inside the playfield window
//   line_tick    one-Clk pulse when DrawX becomes 0
//   frame_tick   one-Clk pulse when (DrawX, DrawY) becomes (0, V_ACTIVE)
//   DrawX, DrawY current column / row
//   frame_count  frames completed, wraps
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int WIN_X0   = 240,
   parameter int WIN_X1   = 400,
   parameter int WIN_Y0   = 80,
   parameter int WIN_Y1   = 384
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        Enable,
   output logic        pixel_ce,
   output logic        hs,
   output logic        vs,
   output logic        blank,
   output logic        sync,
   output logic        in_window,
   output logic        line_tick,
   output logic        frame_tick,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] WX0      = 10'(WIN_X0);
   localparam logic [9:0] WX1      = 10'(WIN_X1);
   localparam logic [9:0] WY0      = 10'(WIN_Y0);
   localparam logic [9:0] WY1      = 10'(WIN_Y1);
   // An empty or inverted window must never flag a pixel.
   localparam logic       WIN_OK   = (WIN_X0 < WIN_X1) && (WIN_Y0 < WIN_Y1);
   localparam logic       HS_ON    = 1'(HS_POL);
   localparam logic       VS_ON    = 1'(VS_POL);

   localparam int              PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0] presc, presc_n;
   // ce_arm is "prescaler sits at its last count", held as a register so that
   // it is 0 out of reset even when CLK_DIV = 1 (prescaler permanently 0).
   logic          ce_arm;
   logic          step;
   logic          x_last, y_last;
   logic [9:0]    x_n, y_n;
   logic          hs_n, vs_n, blank_n, win_n;
   logic          lt_q, ft_q;
   logic          frame_start;

   always_comb begin
      presc_n = (presc == PRESC_LAST) ? '0 : presc + 1'b1;
      step    = Enable & ce_arm;
      x_last  = (DrawX == H_LAST);
      y_last  = (DrawY == V_LAST);

      x_n = DrawX;
      y_n = DrawY;
      if (step) begin
         if (x_last) begin
            x_n = '0;
            y_n = y_last ? '0 : DrawY + 10'd1;
         end else begin
            x_n = DrawX + 10'd1;
         end
      end

      // Decode from the next coordinates so the registered flags land on the
      // same edge as the counters.
      hs_n    = (x_n >= HS_START && x_n < HS_END) ? HS_ON : ~HS_ON;
      vs_n    = (y_n >= VS_START && y_n < VS_END) ? VS_ON : ~VS_ON;
      blank_n = (x_n < H_ACT) && (y_n < V_ACT);
      win_n   = WIN_OK && blank_n &&
                (x_n >= WX0) && (x_n < WX1) &&
                (y_n >= WY0) && (y_n < WY1);

      frame_start = step && x_last && (y_n == V_ACT);
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         presc       <= '0;
         ce_arm      <= 1'b0;
         DrawX       <= '0;
         DrawY       <= '0;
         frame_count <= '0;
         hs          <= ~HS_ON;
         vs          <= ~VS_ON;
         blank       <= 1'b0;
         in_window   <= 1'b0;
         lt_q        <= 1'b0;
         ft_q        <= 1'b0;
      end else if (Enable) begin
         presc     <= presc_n;
         ce_arm    <= (presc_n == PRESC_LAST);
         DrawX     <= x_n;
         DrawY     <= y_n;
         hs        <= hs_n;
         vs        <= vs_n;
         blank     <= blank_n;
         in_window <= win_n;
         lt_q      <= step & x_last;
         ft_q      <= frame_start;
         if (frame_start)
            frame_count <= frame_count + 16'd1;
      end else begin
         // Frozen: everything holds, but a pending tick is dropped so it
         // cannot reappear after resume.
         lt_q <= 1'b0;
         ft_q <= 1'b0;
      end
   end

   // Strobes are gated by Enable so they read 0 in any frozen cycle.
   assign pixel_ce   = step;
   assign line_tick  = lt_q & Enable;
   assign frame_tick = ft_q & Enable;
   assign sync       = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

   logic Clk;
   logic rst_a, en_a, rst_b, en_b, rst_c, en_c;
   logic a_pce, a_hs, a_vs, a_bl, a_sync, a_iw, a_lt, a_ft;
   logic b_pce, b_hs, b_vs, b_bl, b_sync, b_iw, b_lt, b_ft;
   logic c_pce, c_hs, c_vs, c_bl, c_sync, c_iw, c_lt, c_ft;
   logic [9:0]  a_x, a_y, b_x, b_y, c_x, c_y;
   logic [15:0] a_fc, b_fc, c_fc;

   int checks = 0;
   int failures = 0;
   int sb_fail_lines = 0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // A: default 640x480 timing
   vga_timing_gen u_a (
      .Clk(Clk), .Reset_n(rst_a), .Enable(en_a), .pixel_ce(a_pce), .hs(a_hs), .vs(a_vs),
      .blank(a_bl), .sync(a_sync), .in_window(a_iw), .line_tick(a_lt), .frame_tick(a_ft),
      .DrawX(a_x), .DrawY(a_y), .frame_count(a_fc));

   // B: CLK_DIV=1, tiny raster 14x7, hs active-high, empty window
   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1), .VS_POL(0),
      .WIN_X0(5), .WIN_X1(3), .WIN_Y0(1), .WIN_Y1(3)
   ) u_b (
      .Clk(Clk), .Reset_n(rst_b), .Enable(en_b), .pixel_ce(b_pce), .hs(b_hs), .vs(b_vs),
      .blank(b_bl), .sync(b_sync), .in_window(b_iw), .line_tick(b_lt), .frame_tick(b_ft),
      .DrawX(b_x), .DrawY(b_y), .frame_count(b_fc));

   // C: CLK_DIV=2, 24x18 raster, window x 4..9, y 3..8 (scoreboarded)
   vga_timing_gen #(
      .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2), .HS_POL(0), .VS_POL(0),
      .WIN_X0(4), .WIN_X1(10), .WIN_Y0(3), .WIN_Y1(9)
   ) u_c (
      .Clk(Clk), .Reset_n(rst_c), .Enable(en_c), .pixel_ce(c_pce), .hs(c_hs), .vs(c_vs),
      .blank(c_bl), .sync(c_sync), .in_window(c_iw), .line_tick(c_lt), .frame_tick(c_ft),
      .DrawX(c_x), .DrawY(c_y), .frame_count(c_fc));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- scoreboard for instance C ----------------
   typedef struct {
      int p, x, y, fc;
      logic hs, vs, bl, iw, lt, ft;
   } mst_t;

   typedef struct packed {
      logic pce, hs, vs, bl, iw, lt, ft;
      logic [9:0] x, y;
      logic [15:0] fc;
   } obs_t;

   mst_t ms;
   obs_t sbq[$];

   function automatic mst_t mstep(mst_t s, logic rn, logic en);
      mst_t n = s;
      n.lt = 1'b0;
      n.ft = 1'b0;
      if (!rn) begin
         n.p = 0; n.x = 0; n.y = 0; n.fc = 0;
         n.hs = 1'b1; n.vs = 1'b1; n.bl = 1'b0; n.iw = 1'b0;
         return n;
      end
      if (!en) return n;
      if (s.p == 1) begin
         n.p = 0;
         n.x = s.x + 1;
         if (n.x == 24) begin
            n.x = 0;
            n.lt = 1'b1;
            n.y = (s.y + 1) % 18;
            if (n.y == 12) begin
               n.ft = 1'b1;
               n.fc = (s.fc + 1) % 65536;
            end
         end
      end else begin
         n.p = s.p + 1;
      end
      n.hs = !(n.x >= 18 && n.x < 22);
      n.vs = !(n.y >= 14 && n.y < 16);
      n.bl = (n.x < 16) && (n.y < 12);
      n.iw = n.bl && (n.x >= 4) && (n.x < 10) && (n.y >= 3) && (n.y < 9);
      return n;
   endfunction

   function automatic obs_t mkobs(mst_t s, logic en);
      obs_t o;
      o.pce = en && (s.p == 1);
      o.hs  = s.hs;
      o.vs  = s.vs;
      o.bl  = s.bl;
      o.iw  = s.iw;
      o.lt  = s.lt & en;
      o.ft  = s.ft & en;
      o.x   = 10'(s.x);
      o.y   = 10'(s.y);
      o.fc  = 16'(s.fc);
      return o;
   endfunction

   // Push the expected outcome of each edge; inputs are stable here.
   initial forever begin
      mst_t n;
      @(posedge Clk);
      n = mstep(ms, rst_c, en_c);
      ms = n;
      sbq.push_back(mkobs(n, en_c));
   end

   // Pop and compare half a cycle later.
   initial forever begin
      obs_t e, a;
      @(negedge Clk);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         a = {c_pce, c_hs, c_vs, c_bl, c_iw, c_lt, c_ft, c_x, c_y, c_fc};
         checks++;
         if (a !== e) begin
            failures++;
            if (sb_fail_lines < 8) begin
               sb_fail_lines++;
               $display("FAIL sb_c @%0t: got %h expected %h", $time, a, e);
            end
         end
      end
   end

   // ---------------- instance A: default timing ----------------
   task automatic test_a();
      int prevx, n, len, hs_cnt, bl_cnt, pix, hs_first, hs_last, bad;
      logic frozen;
      logic [39:0] snap;
      for (int k = 1; k <= 6; k++) begin
         @(negedge Clk);
         chk($sformatf("a_pce_s%0d", k), a_pce, k % 2);
         if (k == 1) chk("a_x_s1", a_x, 0);
         if (k == 2) chk("a_x_s2", a_x, 1);
      end
      n = 0;
      prevx = a_x;
      do begin
         prevx = a_x;
         @(negedge Clk);
         n++;
      end while (!a_lt && n < 2000);
      chk("a_first_lt", a_lt, 1);
      chk("a_x_before_wrap", prevx, 799);
      chk("a_x_after_wrap", a_x, 0);
      chk("a_y_after_wrap", a_y, 1);

      len = 0; hs_cnt = 0; bl_cnt = 0; hs_first = -1; hs_last = -1;
      do begin
         @(negedge Clk);
         len++;
         if (!a_hs) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = a_x;
            hs_last = a_x;
         end
         if (a_bl) bl_cnt++;
      end while (!a_lt && len < 3000);
      chk("a_line_clk", len, 1600);
      chk("a_hs_clk", hs_cnt, 192);
      chk("a_hs_first_x", hs_first, 656);
      chk("a_hs_last_x", hs_last, 751);
      chk("a_blank_clk", bl_cnt, 1280);

      // Line with a 37-cycle freeze at DrawX = 100
      len = 0; pix = 0; bad = 0; frozen = 1'b0;
      do begin
         @(negedge Clk);
         len++;
         if (a_pce) pix++;
         if (!frozen && a_x == 10'd100) begin
            snap = {a_hs, a_vs, a_bl, a_iw, a_x, a_y, a_fc};
            #1 en_a = 1'b0;
            repeat (37) begin
               @(negedge Clk);
               len++;
               if ({a_hs, a_vs, a_bl, a_iw, a_x, a_y, a_fc} !== snap || a_pce || a_lt || a_ft)
                  bad++;
            end
            #1 en_a = 1'b1;
            frozen = 1'b1;
         end
      end while (!a_lt && len < 3000);
      chk("a_freeze_seen", frozen, 1);
      chk("a_freeze_hold", bad, 0);
      chk("a_frozen_line_clk", len, 1637);
      chk("a_frozen_line_pix", pix, 800);
      len = 0;
      do begin
         @(negedge Clk);
         len++;
      end while (!a_lt && len < 3000);
      chk("a_line_after_resume", len, 1600);
   endtask

   // ---------------- instance B: CLK_DIV=1, tiny raster ----------------
   task automatic test_b();
      int minx = 1000, maxx = -1, vminy = 1000, vmaxy = -1, mx = 0, my = 0;
      int pce_bad = 0, iw_bad = 0, bl_bad = 0, ftn = 0, last_ft = -1, ft_int = 0;
      for (int k = 1; k <= 260; k++) begin
         @(negedge Clk);
         if (!b_pce) pce_bad++;
         if (b_iw) iw_bad++;
         if (b_bl && (b_x >= 10'd8 || b_y >= 10'd4)) bl_bad++;
         if (b_hs) begin
            if (int'(b_x) < minx) minx = b_x;
            if (int'(b_x) > maxx) maxx = b_x;
         end
         if (!b_vs) begin
            if (int'(b_y) < vminy) vminy = b_y;
            if (int'(b_y) > vmaxy) vmaxy = b_y;
         end
         if (int'(b_x) > mx) mx = b_x;
         if (int'(b_y) > my) my = b_y;
         if (b_ft) begin
            ftn++;
            if (last_ft >= 0) ft_int = k - last_ft;
            last_ft = k;
         end
      end
      chk("b_pce_continuous", pce_bad, 0);
      chk("b_win_empty", iw_bad, 0);
      chk("b_blank_region", bl_bad, 0);
      chk("b_hs_min_x", minx, 10);
      chk("b_hs_max_x", maxx, 11);
      chk("b_vs_min_y", vminy, 5);
      chk("b_vs_max_y", vmaxy, 5);
      chk("b_max_x", mx, 13);
      chk("b_max_y", my, 6);
      chk("b_frame_ticks", ftn, 3);
      chk("b_frame_clk", ft_int, 98);
      chk("b_frame_count", b_fc, 3);
   endtask

   // ---------------- instance C: table + corner sequences ----------------
   typedef struct {
      int x, y;
      logic bl, iw, hs, vs;
   } vec_t;

   task automatic test_c();
      vec_t tbl[17];
      int ftn, ft_bad, len, n;
      logic prev_ft, frozen;
      tbl = '{
         '{15, 11, 1'b1, 1'b0, 1'b1, 1'b1},
         '{16,  0, 1'b0, 1'b0, 1'b1, 1'b1},
         '{ 0, 12, 1'b0, 1'b0, 1'b1, 1'b1},
         '{ 5,  4, 1'b1, 1'b1, 1'b1, 1'b1},
         '{ 9,  8, 1'b1, 1'b1, 1'b1, 1'b1},
         '{10,  5, 1'b1, 1'b0, 1'b1, 1'b1},
         '{ 7,  9, 1'b1, 1'b0, 1'b1, 1'b1},
         '{ 3,  5, 1'b1, 1'b0, 1'b1, 1'b1},
         '{ 4,  3, 1'b1, 1'b1, 1'b1, 1'b1},
         '{17,  2, 1'b0, 1'b0, 1'b1, 1'b1},
         '{18,  2, 1'b0, 1'b0, 1'b0, 1'b1},
         '{21,  2, 1'b0, 1'b0, 1'b0, 1'b1},
         '{22,  2, 1'b0, 1'b0, 1'b1, 1'b1},
         '{ 0, 13, 1'b0, 1'b0, 1'b1, 1'b1},
         '{ 0, 14, 1'b0, 1'b0, 1'b1, 1'b0},
         '{23, 15, 1'b0, 1'b0, 1'b1, 1'b0},
         '{ 0, 16, 1'b0, 1'b0, 1'b1, 1'b1}
      };

      // Three frames from release: ticks at (0,12), one Clk wide
      ftn = 0; ft_bad = 0; prev_ft = 1'b0;
      for (int k = 1; k <= 2320; k++) begin
         @(negedge Clk);
         if (c_ft) begin
            ftn++;
            if (c_x != 10'd0 || c_y != 10'd12) ft_bad++;
            if (prev_ft) ft_bad++;
         end
         prev_ft = c_ft;
      end
      chk("c_frame_ticks", ftn, 3);
      chk("c_tick_shape", ft_bad, 0);
      chk("c_frame_count", c_fc, 3);

      // Frame length with a 37-cycle freeze, then a normal frame
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (!c_ft && n < 2000);
      chk("c_ft_found", c_ft, 1);
      len = 0; frozen = 1'b0;
      do begin
         @(negedge Clk);
         len++;
         if (!frozen && c_y == 10'd5) begin
            #1 en_c = 1'b0;
            repeat (37) begin
               @(negedge Clk);
               len++;
            end
            #1 en_c = 1'b1;
            frozen = 1'b1;
         end
      end while (!c_ft && len < 3000);
      chk("c_frozen_frame_clk", len, 901);
      len = 0;
      do begin
         @(negedge Clk);
         len++;
      end while (!c_ft && len < 3000);
      chk("c_frame_clk", len, 864);

      // Table of pixel positions
      foreach (tbl[i]) begin
         n = 0;
         do begin
            @(negedge Clk);
            n++;
         end while (!(int'(c_x) == tbl[i].x && int'(c_y) == tbl[i].y) && n < 1800);
         chk($sformatf("c_tbl%0d_reach", i), {c_x, c_y}, {10'(tbl[i].x), 10'(tbl[i].y)});
         chk($sformatf("c_tbl%0d_blank", i), c_bl, tbl[i].bl);
         chk($sformatf("c_tbl%0d_win", i), c_iw, tbl[i].iw);
         chk($sformatf("c_tbl%0d_hs", i), c_hs, tbl[i].hs);
         chk($sformatf("c_tbl%0d_vs", i), c_vs, tbl[i].vs);
      end

      // One-cycle reset mid-frame
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (c_y != 10'd9 && n < 1000);
      #1 rst_c = 1'b0;
      @(negedge Clk);
      chk("c_rst_xy", {c_x, c_y}, 0);
      chk("c_rst_fc", c_fc, 0);
      chk("c_rst_flags", {c_hs, c_vs, c_bl, c_iw, c_pce, c_lt, c_ft}, 7'b1100000);
      #1 rst_c = 1'b1;

      // Random Enable / occasional reset, checked by the scoreboard
      repeat (600) begin
         @(negedge Clk);
         #1;
         en_c  = ($urandom_range(0, 3) != 0);
         rst_c = ($urandom_range(0, 199) != 0);
      end
      @(negedge Clk);
      #1 en_c = 1'b1;
      rst_c = 1'b1;
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      en_a = 1'b1;  en_b = 1'b1;  en_c = 1'b1;
      repeat (5) @(negedge Clk);
      chk("a_rst_xy", {a_x, a_y}, 0);
      chk("a_rst_fc", a_fc, 0);
      chk("a_rst_flags", {a_hs, a_vs, a_bl, a_iw, a_pce, a_lt, a_ft, a_sync}, 8'b11000000);
      chk("b_rst_pce", b_pce, 0);
      chk("b_rst_hs", b_hs, 0);
      chk("b_rst_vs", b_vs, 1);
      #1;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      fork
         test_a();
         test_b();
         test_c();
      join
      repeat (2) @(negedge Clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #(10 * 80000);
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
